team_06_button_conditioner: RTL and testbench



---
 rtl/team_06_pkg.sv | 30 +++
 rtl/team_06_button_channel.sv | 134 +++++++++++++
 rtl/team_06_button_conditioner.sv | 75 +++++++
 tb/tb_team_06_button_conditioner.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/team_06_pkg.sv
// Shared definitions for the push-button front end: channel indices,
// per-channel state encoding and the 40 MHz default timing.
package team_06_pkg;

    // Channel index of each game button on the GPIO vector
    localparam int BTN_RESET = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 4;
    localparam int BTN_START = 5;

    // Default timing at 40 MHz
    localparam int DEF_NUM_BTN         = 6;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 400000;    // 10 ms
    localparam int DEF_REPEAT_DELAY    = 20000000;  // 500 ms
    localparam int DEF_REPEAT_RATE     = 4000000;   // 100 ms
    localparam int DEF_CNT_W           = 25;
    localparam int DEF_ID_W            = 3;
    localparam logic [DEF_NUM_BTN-1:0] DEF_REPEAT_MASK = 6'b011110;

    // Per-channel press state
    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_HELD      = 2'd1,
        ST_REPEATING = 2'd2
    } btn_state_e;

endpackage

// File: rtl/team_06_button_channel.sv
// One button channel: pad synchroniser, debounce filter and a
// RELEASED/HELD/REPEATING state machine producing single-cycle pulses.
module team_06_button_channel
    import team_06_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic event_o,
    output logic event_next_o
);

    localparam logic [CNT_W-1:0] DEB_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_TC  = CNT_W'(REPEAT_RATE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]       rpt_cnt_q, rpt_cnt_d;
    btn_state_e             state_q, state_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   event_q, event_d;
    logic                   deb_toggle, rise, fall, rpt_fire;

    // Synchroniser runs regardless of enable so the sample is always fresh
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    assign sample     = sync_q[SYNC_STAGES-1];
    assign deb_toggle = en_i && (sample != level_q) && (deb_cnt_q == DEB_TC);
    assign rise       = deb_toggle && !level_q;
    assign fall       = deb_toggle && level_q;

    // Debounce: count consecutive disagreeing samples, flip level at terminal count
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = '0;
        if (!en_i) begin
            level_d = 1'b0;
        end else if (sample != level_q) begin
            if (deb_cnt_q == DEB_TC) level_d = ~level_q;
            else                     deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
    end

    // Debounce registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // State register, repeat counter and registered pulse outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_RELEASED;
            rpt_cnt_q <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            event_q   <= event_d;
        end
    end

    // Next state; the repeat counter only runs on repeat-enabled channels so it never wraps
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = '0;
        unique case (state_q)
            ST_RELEASED: begin
                if (rise) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (fall) begin
                    state_d = ST_RELEASED;
                end else if (REPEAT_EN) begin
                    if (rpt_cnt_q == DELAY_TC) state_d = ST_REPEATING;
                    else                       rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                end
            end
            ST_REPEATING: begin
                if (fall)                     state_d = ST_RELEASED;
                else if (rpt_cnt_q != RATE_TC) rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
            end
            default: state_d = ST_RELEASED;
        endcase
        if (!en_i) begin
            state_d   = ST_RELEASED;
            rpt_cnt_d = '0;
        end
    end

    // Pulse decode; a release in the same cycle wins over a repeat
    always_comb begin
        press_d   = (state_q == ST_RELEASED) && rise;
        release_d = (state_q != ST_RELEASED) && fall;
        rpt_fire  = en_i && !fall &&
                    (((state_q == ST_HELD) && REPEAT_EN && (rpt_cnt_q == DELAY_TC)) ||
                     ((state_q == ST_REPEATING) && (rpt_cnt_q == RATE_TC)));
        event_d   = press_d || rpt_fire;
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign event_o      = event_q;
    assign event_next_o = event_d;

endmodule

// File: rtl/team_06_button_conditioner.sv
// N-channel button front end: one conditioning channel per pad plus a
// registered lowest-index priority encoder over the event vector.
module team_06_button_conditioner
    import team_06_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK = NUM_BTN'(DEF_REPEAT_MASK),
    parameter int CNT_W           = DEF_CNT_W,
    parameter int ID_W            = DEF_ID_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [NUM_BTN-1:0] btn_raw_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o,
    output logic [NUM_BTN-1:0] btn_event_o,
    output logic               evt_valid_o,
    output logic [ID_W-1:0]    evt_id_o
);

    logic [NUM_BTN-1:0] evt_next;
    logic               evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]    evt_id_q, evt_id_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        team_06_button_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_MASK[i]),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .en_i         (en_i),
            .raw_i        (btn_raw_i[i]),
            .level_o      (btn_level_o[i]),
            .press_o      (btn_press_o[i]),
            .release_o    (btn_release_o[i]),
            .event_o      (btn_event_o[i]),
            .event_next_o (evt_next[i])
        );
    end

    // Encode from the channels' next-cycle events so evt_* line up with btn_event
    always_comb begin
        evt_valid_d = |evt_next;
        evt_id_d    = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (evt_next[i]) evt_id_d = ID_W'(i);
        end
    end

    // Encoder output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_id_o    = evt_id_q;

endmodule

// File: tb/tb_team_06_button_conditioner.sv
// Scoreboard bench: each scenario's raw/en waveform is turned into expected
// output records by a window-based reference model, queued, and compared by
// an independent monitor whenever the DUT shows any pulse.
module tb_team_06_button_conditioner;
    import team_06_pkg::*;

    localparam int NB   = 6;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RR   = 5;
    localparam int IDW  = 3;
    localparam int CW   = 8;
    localparam int MAXC = 200;
    localparam logic [NB-1:0] MASK = 6'b011110;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_event;
    logic          evt_valid;
    logic [IDW-1:0] evt_id;

    team_06_button_conditioner #(
        .NUM_BTN         (NB),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .REPEAT_MASK     (MASK),
        .CNT_W           (CW),
        .ID_W            (IDW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .btn_raw_i     (btn_raw),
        .btn_level_o   (btn_level),
        .btn_press_o   (btn_press),
        .btn_release_o (btn_release),
        .btn_event_o   (btn_event),
        .evt_valid_o   (evt_valid),
        .evt_id_o      (evt_id)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        int             edge_n;
        logic [NB-1:0]  press;
        logic [NB-1:0]  rel;
        logic [NB-1:0]  evt;
        logic [NB-1:0]  lvl;
        logic           valid;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [NB-1:0] raw_a [0:MAXC];
    logic          en_a  [0:MAXC];

    // ---------------- monitor ----------------
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            #1;
            while (exp_q.size() > 0) begin
                n_cmp++; n_bad++;
                $display("FAIL missing_event edge=%0d: no output seen, required evt=%b press=%b rel=%b",
                         exp_q[0].edge_n, exp_q[0].evt, exp_q[0].press, exp_q[0].rel);
                void'(exp_q.pop_front());
            end
            n_cmp++;
            if ({btn_level, btn_press, btn_release, btn_event, evt_valid, evt_id} != '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got lvl=%b press=%b rel=%b evt=%b valid=%b id=%0d, required all 0",
                         btn_level, btn_press, btn_release, btn_event, evt_valid, evt_id);
            end
        end else begin
            while (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
                n_cmp++; n_bad++;
                $display("FAIL missing_event edge=%0d: no output seen, required evt=%b press=%b rel=%b",
                         exp_q[0].edge_n, exp_q[0].evt, exp_q[0].press, exp_q[0].rel);
                void'(exp_q.pop_front());
            end
            if ((btn_press | btn_release | btn_event) != '0 || evt_valid) begin
                n_cmp++;
                if (exp_q.size() == 0 || exp_q[0].edge_n != edge_cnt) begin
                    n_bad++;
                    $display("FAIL unexpected_output edge=%0d: got press=%b rel=%b evt=%b valid=%b id=%0d, required none",
                             edge_cnt, btn_press, btn_release, btn_event, evt_valid, evt_id);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (btn_press !== mon_e.press || btn_release !== mon_e.rel || btn_event !== mon_e.evt ||
                        btn_level !== mon_e.lvl || evt_valid !== mon_e.valid || evt_id !== mon_e.id) begin
                        n_bad++;
                        $display("FAIL event_check edge=%0d: got press=%b rel=%b evt=%b lvl=%b valid=%b id=%0d, required press=%b rel=%b evt=%b lvl=%b valid=%b id=%0d",
                                 edge_cnt, btn_press, btn_release, btn_event, btn_level, evt_valid, evt_id,
                                 mon_e.press, mon_e.rel, mon_e.evt, mon_e.lvl, mon_e.valid, mon_e.id);
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Synchronised sample seen at edge e is the pad level applied before edge e-SYNC.
    function automatic logic samp(int e, int ch);
        if (e - SYNC >= 1) return raw_a[e - SYNC][ch];
        return 1'b0;
    endfunction

    task automatic build_model(input int n);
        logic [NB-1:0] lv [0:MAXC];
        logic [NB-1:0] pr [0:MAXC];
        logic [NB-1:0] rl [0:MAXC];
        logic [NB-1:0] ev [0:MAXC];
        exp_t r;
        for (int c = 0; c <= MAXC; c++) begin
            lv[c] = '0; pr[c] = '0; rl[c] = '0; ev[c] = '0;
        end
        // Level flips once DEB consecutive enabled samples disagree with a steady level.
        for (int c = 1; c <= n; c++) begin
            for (int ch = 0; ch < NB; ch++) begin
                if (!en_a[c]) begin
                    lv[c][ch] = 1'b0;
                end else begin
                    logic tog;
                    tog = 1'b1;
                    for (int j = 0; j < DEB; j++) begin
                        int e;
                        e = c - j;
                        if (e < 1) tog = 1'b0;
                        else if (!en_a[e] || samp(e, ch) == lv[c-1][ch] || lv[e-1][ch] != lv[c-1][ch])
                            tog = 1'b0;
                    end
                    lv[c][ch] = lv[c-1][ch] ^ tog;
                end
                pr[c][ch] = en_a[c] && lv[c][ch] && !lv[c-1][ch];
                rl[c][ch] = en_a[c] && !lv[c][ch] && lv[c-1][ch];
            end
        end
        // Repeats at T+RD+k*RR while the level stays high (strictly before the fall edge).
        for (int ch = 0; ch < NB; ch++) begin
            for (int t = 1; t <= n; t++) begin
                if (pr[t][ch]) begin
                    int stop;
                    stop = t + 1;
                    while (stop <= n && lv[stop][ch]) stop++;
                    ev[t][ch] = 1'b1;
                    if (MASK[ch]) begin
                        for (int rr = t + RD; rr < stop && rr <= n; rr += RR) ev[rr][ch] = 1'b1;
                    end
                end
            end
        end
        for (int c = 1; c <= n; c++) begin
            if ((pr[c] | rl[c] | ev[c]) != '0) begin
                r.edge_n = c;
                r.press  = pr[c];
                r.rel    = rl[c];
                r.evt    = ev[c];
                r.lvl    = lv[c];
                r.valid  = |ev[c];
                r.id     = '0;
                for (int ch = NB - 1; ch >= 0; ch--) if (ev[c][ch]) r.id = IDW'(ch);
                pend.push_back(r);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic do_reset();
        #1;
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_stim();
        for (int c = 0; c <= MAXC; c++) begin
            raw_a[c] = '0;
            en_a[c]  = 1'b1;
        end
    endtask

    task automatic set_hold(input int ch, input int from, input int to);
        for (int c = from; c <= to; c++) raw_a[c][ch] = 1'b1;
    endtask

    task automatic run_scenario(input int n);
        int   base;
        exp_t e;
        build_model(n);
        base = edge_cnt;
        while (pend.size() > 0) begin
            e = pend.pop_front();
            e.edge_n += base;
            exp_q.push_back(e);
        end
        for (int c = 1; c <= n; c++) begin
            btn_raw = raw_a[c];
            en      = en_a[c];
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic gen_random(input int n);
        clear_stim();
        for (int ch = 0; ch < NB; ch++) begin
            logic v;
            int   c;
            v = 1'($urandom_range(0, 1));
            c = 1;
            while (c <= n) begin
                int len;
                len = int'($urandom_range(1, 30));
                for (int k = 0; k < len && c <= n; k++) begin
                    raw_a[c][ch] = v;
                    c++;
                end
                v = ~v;
            end
        end
        for (int d = 0; d < int'($urandom_range(0, 2)); d++) begin
            int st, ln;
            st = int'($urandom_range(5, n - 10));
            ln = int'($urandom_range(1, 5));
            for (int k = 0; k < ln; k++) en_a[st + k] = 1'b0;
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        btn_raw = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Hold RIGHT and reset exactly while its first repeat pulse is showing
        clear_stim(); set_hold(BTN_RIGHT, 1, 16); run_scenario(16);
        // RIGHT still high out of reset: fresh press after SYNC+DEB edges
        clear_stim(); set_hold(BTN_RIGHT, 1, 20); run_scenario(20);
        // UP: 3-cycle glitch filtered, then a 4-cycle pulse accepted
        clear_stim(); set_hold(BTN_UP, 1, 3); set_hold(BTN_UP, 13, 16); run_scenario(30);
        // RIGHT held 40 cycles: repeats, release coincides with a repeat slot
        clear_stim(); set_hold(BTN_RIGHT, 1, 40); run_scenario(55);
        // START held 40 cycles: no auto-repeat
        clear_stim(); set_hold(BTN_START, 1, 40); run_scenario(55);
        // LEFT and DOWN together: lowest index wins evt_id
        clear_stim(); set_hold(BTN_LEFT, 3, 20); set_hold(BTN_DOWN, 3, 20); run_scenario(30);
        // DOWN held through an enable drop: silent clear, then fresh press
        clear_stim(); set_hold(BTN_DOWN, 1, 30);
        for (int c = 8; c <= 10; c++) en_a[c] = 1'b0;
        run_scenario(30);

        for (int s = 0; s < 8; s++) begin
            gen_random(150);
            run_scenario(150);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
